ap_vec_engine: RTL

AP_VEC_ENGINE -- requirements
Module: ap_vec_engine

---
 rtl/ap_pkg.sv | 40 ++++
 rtl/ap_pass_lut.sv | 42 ++++
 rtl/ap_vec_engine.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ap_pkg.sv
// Shared definitions for the associative vector engine: opcodes, FSM states,
// per-pass truth tables and the opcode legality check.
// Build option: define AP_ADD_EN to enable the bit-serial ADD opcode.
package ap_pkg;

  typedef enum logic [2:0] {
    OP_OR   = 3'd0,
    OP_AND  = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOTA = 3'd3,
    OP_ADD  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Logic-op tables are indexed by {key_a, key_b}.
  localparam logic [3:0] LUT_OR   = 4'b1110;
  localparam logic [3:0] LUT_AND  = 4'b1000;
  localparam logic [3:0] LUT_XOR  = 4'b0110;
  localparam logic [3:0] LUT_NOTA = 4'b0011;

  // ADD tables are indexed by {key_a, key_b, key_cin}.
  localparam logic [7:0] LUT_ADD_SUM  = 8'b1001_0110;
  localparam logic [7:0] LUT_ADD_COUT = 8'b1110_1000;

  // Opcodes 5-7 are always illegal; ADD is legal only when carry storage exists.
  function automatic logic op_legal(input logic [2:0] op);
`ifdef AP_ADD_EN
    return (op <= 3'd4);
`else
    return (op <= 3'd3);
`endif
  endfunction

endpackage

// File: rtl/ap_pass_lut.sv
// Pass table: for a given opcode and pass number, the search keys applied in
// COMPARE and the value written to tagged rows in WRITE.
module ap_pass_lut
  import ap_pkg::*;
(
  input  op_e        op,
  input  logic [2:0] pass,
  output logic       key_a,
  output logic       key_b,
  output logic       key_cin,
  output logic       result,
  output logic       cout,
  output logic       last_pass
);

  // Decode keys and write values; logic ops sweep {a,b}, ADD sweeps {a,b,cin}.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    key_a     = pass[1];
    key_b     = pass[0];
    key_cin   = 1'b0;
    result    = 1'b0;
    cout      = 1'b0;
    last_pass = (pass == 3'd3);
    case (op)
      OP_OR:   result = LUT_OR[pass[1:0]];
      OP_AND:  result = LUT_AND[pass[1:0]];
      OP_XOR:  result = LUT_XOR[pass[1:0]];
      OP_NOTA: result = LUT_NOTA[pass[1:0]];
      OP_ADD: begin
        key_a     = pass[2];
        key_b     = pass[1];
        key_cin   = pass[0];
        result    = LUT_ADD_SUM[pass];
        cout      = LUT_ADD_COUT[pass];
        last_pass = (pass == 3'd7);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ap_vec_engine.sv
// Associative vector engine: columns A, B, C of DEPTH rows x WIDTH bits.
// Each operation walks bit positions LSB first; every pass searches all rows
// in parallel for a key pattern (COMPARE) and writes the pass result into the
// matching rows (WRITE).
// Build option: define AP_ADD_EN to add carry columns and the ADD opcode.
module ap_vec_engine
  import ap_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              wr_en,
  input  logic              wr_col,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [1:0]        rd_col,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q;
  logic             err_q;
  logic [BIT_W-1:0] bit_q;
  logic [2:0]       pass_q;
  logic [DEPTH-1:0] tag_q;
  logic [DEPTH-1:0] match;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH-1:0] mem_c [DEPTH];

  logic key_a, key_b, lut_result, last_pass;
  logic accept;

`ifdef AP_ADD_EN
  logic             key_cin, lut_cout;
  logic [DEPTH-1:0] carry_q, ncarry_q, ncarry_next;
`endif

  assign accept = (state_q == ST_IDLE) && start;

  ap_pass_lut u_lut (
    .op        (op_q),
    .pass      (pass_q),
    .key_a     (key_a),
    .key_b     (key_b),
`ifdef AP_ADD_EN
    .key_cin   (key_cin),
    .cout      (lut_cout),
`else
    .key_cin   (),
    .cout      (),
`endif
    .result    (lut_result),
    .last_pass (last_pass)
  );

  // Parallel search of every row at the current bit position.
  always_comb begin
    match = '0;
    for (int r = 0; r < DEPTH; r++) begin
      match[r] = (mem_a[r][bit_q] == key_a) && (mem_b[r][bit_q] == key_b);
`ifdef AP_ADD_EN
      if (op_q == OP_ADD) match[r] = match[r] && (carry_q[r] == key_cin);
`endif
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      ST_IDLE:    if (start) state_d = op_legal(op) ? ST_COMPARE : ST_DONE;
      ST_COMPARE: begin
        busy    = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        busy    = 1'b1;
        state_d = (last_pass && (bit_q == LAST_BIT)) ? ST_DONE : ST_COMPARE;
      end
      ST_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, opcode latch, bit/pass counters and tag column.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_OR;
      err_q   <= 1'b0;
      bit_q   <= '0;
      pass_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (start) begin
          op_q   <= op_e'(op);
          err_q  <= !op_legal(op);
          bit_q  <= '0;
          pass_q <= '0;
          tag_q  <= '0;
        end
        ST_COMPARE: tag_q <= match;
        ST_WRITE: begin
          tag_q <= '0;
          if (last_pass) begin
            pass_q <= '0;
            bit_q  <= bit_q + 1'b1;
          end else begin
            pass_q <= pass_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AP_ADD_EN
  // Carry-out of tagged rows in this pass; rows not tagged keep theirs.
  always_comb begin
    ncarry_next = ncarry_q;
    for (int r = 0; r < DEPTH; r++)
      if (tag_q[r]) ncarry_next[r] = lut_cout;
  end

  // Carry columns: ncarry collects this bit's carries, carry feeds the next bit.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      carry_q  <= '0;
      ncarry_q <= '0;
    end else if (state_q == ST_WRITE) begin
      ncarry_q <= ncarry_next;
      if (last_pass) carry_q <= ncarry_next;
    end
  end
`endif

  // Column storage: host writes A/B in IDLE, the engine writes C in WRITE.
  always_ff @(posedge clk) begin
    // NOTE: the data arrays are deliberately not reset; rst only stops the engine, contents survive.
    if (!rst && (state_q == ST_IDLE) && wr_en) begin
      if (wr_col) mem_b[wr_addr] <= wr_data;
      else        mem_a[wr_addr] <= wr_data;
    end
    if (!rst && (state_q == ST_WRITE)) begin
      for (int r = 0; r < DEPTH; r++)
        if (tag_q[r]) mem_c[r][bit_q] <= lut_result;
    end
  end

  // Combinational read port, live in every state.
  always_comb begin
    rd_data = '0;
    case (rd_col)
      2'd0:    rd_data = mem_a[rd_addr];
      2'd1:    rd_data = mem_b[rd_addr];
      2'd2:    rd_data = mem_c[rd_addr];
      default: rd_data = '0;
    endcase
  end

endmodule
